// File: rtl/time_set_ctrl.sv
// time_set_ctrl: BCD hour/minute/second setter with field cursor,
// inc/dec auto-repeat, load-on-entry and a display blink strobe.
module time_set_ctrl #(
  parameter bit SEC_EN        = 1'b1,
  parameter bit HR24          = 1'b1,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int BLINK_CYCLES  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       sel,
  input  logic       inc,
  input  logic       dec,
  input  logic [3:0] hr_high_i,
  input  logic [3:0] hr_low_i,
  input  logic [3:0] min_high_i,
  input  logic [3:0] min_low_i,
  input  logic [3:0] sec_high_i,
  input  logic [3:0] sec_low_i,
  output logic [3:0] hr_high_o,
  output logic [3:0] hr_low_o,
  output logic [3:0] min_high_o,
  output logic [3:0] min_low_o,
  output logic [3:0] sec_high_o,
  output logic [3:0] sec_low_o,
  output logic       LED_hr,
  output logic       LED_min,
  output logic       LED_sec,
  output logic       blink_o,
  output logic       changed_o
);

  typedef enum logic [1:0] {
    CUR_HR  = 2'd0,
    CUR_MIN = 2'd1,
    CUR_SEC = 2'd2
  } cur_t;

  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(HMAX + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_CYCLES);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_CYCLES - 1);

  localparam logic [7:0] HR_LO_B = HR24 ? 8'h00 : 8'h01;
  localparam logic [7:0] HR_HI_B = HR24 ? 8'h23 : 8'h12;
  localparam logic [7:0] HR_LO_D = HR24 ? 8'd0 : 8'd1;
  localparam logic [7:0] HR_HI_D = HR24 ? 8'd23 : 8'd12;
  localparam logic [7:0] HR_RST  = HR24 ? 8'h00 : 8'h12;

  function automatic logic in_range(
    input logic [7:0] v,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    logic [7:0] d;
    d = ({4'd0, v[7:4]} << 3) + ({4'd0, v[7:4]} << 1)
      + {4'd0, v[3:0]};
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9)
        && (d >= lo) && (d <= hi);
  endfunction

  // Two-digit BCD +/-1 with wrap between lo and hi (both BCD)
  function automatic logic [7:0] bcd_step(
    input logic [7:0] v,
    input logic       up,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    if (up) begin
      if (v == hi) return lo;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
    end
    if (v == lo) return hi;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic          mode_t, sel_t, inc_t, dec_t, settle;
  logic [7:0]    hr, mn, sc, hr_n, mn_n, sc_n;
  logic [7:0]    ld_hr, ld_mn, ld_sc;
  cur_t          cur, cur_n, cur_adv;
  logic          rep_on, rep_up, rep_ph;
  logic          rep_on_n, rep_up_n, rep_ph_n;
  logic [CW-1:0] hcnt, hcnt_n;
  logic          chg, chg_n, blink, blink_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          sel_e, inc_e, dec_e, step, up;

  assign sel_e = sel & ~sel_t;
  assign inc_e = inc & ~inc_t;
  assign dec_e = dec & ~dec_t;

  always_comb begin
    case (cur)
      CUR_HR:  cur_adv = CUR_MIN;
      CUR_MIN: cur_adv = SEC_EN ? CUR_SEC : CUR_HR;
      default: cur_adv = CUR_HR;
    endcase
  end

  always_comb begin
    ld_hr = in_range({hr_high_i, hr_low_i}, HR_LO_D, HR_HI_D) ?
            {hr_high_i, hr_low_i} : HR_LO_B;
    ld_mn = in_range({min_high_i, min_low_i}, 8'd0, 8'd59) ?
            {min_high_i, min_low_i} : 8'h00;
    ld_sc = (SEC_EN &&
             in_range({sec_high_i, sec_low_i}, 8'd0, 8'd59)) ?
            {sec_high_i, sec_low_i} : 8'h00;
  end

  always_comb begin
    hr_n     = hr;
    mn_n     = mn;
    sc_n     = sc;
    cur_n    = cur;
    rep_on_n = rep_on;
    rep_up_n = rep_up;
    rep_ph_n = rep_ph;
    hcnt_n   = hcnt;
    chg_n    = 1'b0;
    blink_n  = blink;
    bcnt_n   = bcnt;
    step     = 1'b0;
    up       = 1'b0;
    if (settle) begin
      // first cycle after reset only samples the buttons
      rep_on_n = 1'b0;
    end else if (mode_t && !mode) begin
      hr_n     = ld_hr;
      mn_n     = ld_mn;
      sc_n     = ld_sc;
      cur_n    = CUR_HR;
      rep_on_n = 1'b0;
      rep_ph_n = 1'b0;
      hcnt_n   = '0;
      blink_n  = 1'b1;
      bcnt_n   = '0;
    end else if (mode) begin
      rep_on_n = 1'b0;
      blink_n  = 1'b0;
      bcnt_n   = '0;
    end else begin
      if (sel_e) cur_n = cur_adv;
      if (bcnt == BLK_LAST) begin
        blink_n = ~blink;
        bcnt_n  = '0;
      end else begin
        bcnt_n = bcnt + BW'(1);
      end
      if (inc && dec) begin
        rep_on_n = 1'b0;
      end else if (inc_e || dec_e) begin
        step     = 1'b1;
        up       = inc_e;
        rep_on_n = 1'b1;
        rep_up_n = inc_e;
        rep_ph_n = 1'b0;
        hcnt_n   = '0;
      end else if (rep_on && (rep_up ? inc : dec)) begin
        up     = rep_up;
        hcnt_n = hcnt + CW'(1);
        if (!rep_ph && hcnt_n == HOLD_C) begin
          step     = 1'b1;
          rep_ph_n = 1'b1;
          hcnt_n   = '0;
        end else if (rep_ph && hcnt_n == REP_C) begin
          step   = 1'b1;
          hcnt_n = '0;
        end
      end else begin
        rep_on_n = 1'b0;
      end
      if (step) begin
        chg_n   = 1'b1;
        blink_n = 1'b1;
        bcnt_n  = '0;
        case (cur)
          CUR_HR:  hr_n = bcd_step(hr, up, HR_LO_B, HR_HI_B);
          CUR_MIN: mn_n = bcd_step(mn, up, 8'h00, 8'h59);
          default: sc_n = bcd_step(sc, up, 8'h00, 8'h59);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_t <= 1'b0;
      sel_t  <= 1'b0;
      inc_t  <= 1'b0;
      dec_t  <= 1'b0;
      settle <= 1'b1;
      hr     <= HR_RST;
      mn     <= 8'h00;
      sc     <= 8'h00;
      cur    <= CUR_HR;
      rep_on <= 1'b0;
      rep_up <= 1'b0;
      rep_ph <= 1'b0;
      hcnt   <= '0;
      chg    <= 1'b0;
      blink  <= 1'b0;
      bcnt   <= '0;
    end else begin
      mode_t <= mode;
      sel_t  <= sel;
      inc_t  <= inc;
      dec_t  <= dec;
      settle <= 1'b0;
      hr     <= hr_n;
      mn     <= mn_n;
      sc     <= sc_n;
      cur    <= cur_n;
      rep_on <= rep_on_n;
      rep_up <= rep_up_n;
      rep_ph <= rep_ph_n;
      hcnt   <= hcnt_n;
      chg    <= chg_n;
      blink  <= blink_n;
      bcnt   <= bcnt_n;
    end
  end

  assign hr_high_o  = hr[7:4];
  assign hr_low_o   = hr[3:0];
  assign min_high_o = mn[7:4];
  assign min_low_o  = mn[3:0];
  assign sec_high_o = sc[7:4];
  assign sec_low_o  = sc[3:0];
  assign LED_hr     = (cur == CUR_HR) & ~mode;
  assign LED_min    = (cur == CUR_MIN) & ~mode;
  assign LED_sec    = SEC_EN & (cur == CUR_SEC) & ~mode;
  assign blink_o    = blink & ~mode;
  assign changed_o  = chg;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: 24h/seconds instance (a) and
// 12h/no-seconds instance (b) driven from shared buttons.
module tb_time_set_ctrl;

  logic        clk, rst, mode, sel, inc, dec;
  logic [23:0] t_i;
  wire  [23:0] a_t, b_t;
  wire         a_lh, a_lm, a_ls, a_blink, a_chg;
  wire         b_lh, b_lm, b_ls, b_blink, b_chg;

  logic [23:0] qa[$];
  logic [23:0] qb[$];
  logic [23:0] ea, eb;
  int          errs, checks;

  time_set_ctrl #(
    .SEC_EN(1'b1), .HR24(1'b1), .HOLD_CYCLES(4),
    .REPEAT_CYCLES(2), .BLINK_CYCLES(8)
  ) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .inc(inc), .dec(dec),
    .hr_high_i(t_i[23:20]), .hr_low_i(t_i[19:16]),
    .min_high_i(t_i[15:12]), .min_low_i(t_i[11:8]),
    .sec_high_i(t_i[7:4]), .sec_low_i(t_i[3:0]),
    .hr_high_o(a_t[23:20]), .hr_low_o(a_t[19:16]),
    .min_high_o(a_t[15:12]), .min_low_o(a_t[11:8]),
    .sec_high_o(a_t[7:4]), .sec_low_o(a_t[3:0]),
    .LED_hr(a_lh), .LED_min(a_lm), .LED_sec(a_ls),
    .blink_o(a_blink), .changed_o(a_chg)
  );

  time_set_ctrl #(
    .SEC_EN(1'b0), .HR24(1'b0), .HOLD_CYCLES(4),
    .REPEAT_CYCLES(2), .BLINK_CYCLES(8)
  ) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .inc(inc), .dec(dec),
    .hr_high_i(t_i[23:20]), .hr_low_i(t_i[19:16]),
    .min_high_i(t_i[15:12]), .min_low_i(t_i[11:8]),
    .sec_high_i(t_i[7:4]), .sec_low_i(t_i[3:0]),
    .hr_high_o(b_t[23:20]), .hr_low_o(b_t[19:16]),
    .min_high_o(b_t[15:12]), .min_low_o(b_t[11:8]),
    .sec_high_o(b_t[7:4]), .sec_low_o(b_t[3:0]),
    .LED_hr(b_lh), .LED_min(b_lm), .LED_sec(b_ls),
    .blink_o(b_blink), .changed_o(b_chg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic enter(input logic [23:0] t);
    mode = 1'b1;
    @(negedge clk);
    t_i  = t;
    mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic pi, input logic pd,
                       input logic ps);
    inc = pi;
    dec = pd;
    sel = ps;
    @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    sel = 1'b0;
  endtask

  task automatic cmp_q(input string nm);
    ea = qa.pop_front();
    eb = qb.pop_front();
    checks++;
    if (a_t !== ea) begin
      errs++;
      $display("FAIL %s_a got %h want %h", nm, a_t, ea);
    end
    checks++;
    if (b_t !== eb) begin
      errs++;
      $display("FAIL %s_b got %h want %h", nm, b_t, eb);
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    mode = 1'b1;
    repeat (2) @(negedge clk);
    qa.push_back(24'h000000);
    qb.push_back(24'h120000);
    cmp_q("reset");
    checks++;
    if ({a_lh, a_chg, a_blink, b_chg} !== 4'b0) begin
      errs++;
      $display("FAIL reset_flags got %b want 0000",
               {a_lh, a_chg, a_blink, b_chg});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load;
    t_i  = 24'h143752;
    mode = 1'b0;
    qa.push_back(24'h143752);
    qb.push_back(24'h013700);
    @(negedge clk);
    cmp_q("load");
    checks++;
    if (a_lh !== 1'b1 || a_chg !== 1'b0) begin
      errs++;
      $display("FAIL load_flags got lh=%b chg=%b want 1 0",
               a_lh, a_chg);
    end
    enter(24'h256109);
    qa.push_back(24'h000009);
    qb.push_back(24'h010000);
    cmp_q("inv_load");
  endtask

  task automatic test_wrap24;
    enter(24'h235900);
    qa.push_back(24'h005900);
    qb.push_back(24'h025900);
    press(1, 0, 0);
    cmp_q("w24_inc_hr");
    checks++;
    if (a_chg !== 1'b1) begin
      errs++;
      $display("FAIL w24_chg got %b want 1", a_chg);
    end
    @(negedge clk);
    checks++;
    if (a_chg !== 1'b0) begin
      errs++;
      $display("FAIL w24_chg_end got %b want 0", a_chg);
    end
    press(0, 0, 1);
    checks++;
    if (a_lm !== 1'b1) begin
      errs++;
      $display("FAIL w24_cursor got %b want 1", a_lm);
    end
    @(negedge clk);
    qa.push_back(24'h000000);
    qb.push_back(24'h020000);
    press(1, 0, 0);
    cmp_q("w24_inc_min");
    @(negedge clk);
    qa.push_back(24'h005900);
    qb.push_back(24'h025900);
    press(0, 1, 0);
    cmp_q("w24_dec_min");
    @(negedge clk);
  endtask

  task automatic test_wrap12;
    enter(24'h120000);
    qa.push_back(24'h130000);
    qb.push_back(24'h010000);
    press(1, 0, 0);
    cmp_q("w12_inc");
    @(negedge clk);
    qa.push_back(24'h120000);
    qb.push_back(24'h120000);
    press(0, 1, 0);
    cmp_q("w12_dec1");
    @(negedge clk);
    qa.push_back(24'h110000);
    qb.push_back(24'h110000);
    press(0, 1, 0);
    cmp_q("w12_dec2");
    @(negedge clk);
  endtask

  task automatic test_blink;
    qa.push_back(24'h120000);
    qb.push_back(24'h120000);
    press(1, 0, 0);
    cmp_q("blink_step");
    checks++;
    if (a_blink !== 1'b1) begin
      errs++;
      $display("FAIL blink_on got %b want 1", a_blink);
    end
    repeat (7) @(negedge clk);
    checks++;
    if (a_blink !== 1'b1) begin
      errs++;
      $display("FAIL blink_hold got %b want 1", a_blink);
    end
    @(negedge clk);
    checks++;
    if (a_blink !== 1'b0) begin
      errs++;
      $display("FAIL blink_off got %b want 0", a_blink);
    end
  endtask

  task automatic test_repeat;
    int pulses;
    int n;
    logic exp_chg;
    pulses = 0;
    n = 0;
    enter(24'h001000);
    press(0, 0, 1);
    @(negedge clk);
    inc = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_chg = (i == 0) || (i == 4) || (i == 6) || (i == 8);
      if (exp_chg) n++;
      qa.push_back({8'h00, 8'h10 + 8'(n), 8'h00});
      @(negedge clk);
      ea = qa.pop_front();
      checks++;
      if (a_t !== ea || a_chg !== exp_chg) begin
        errs++;
        $display("FAIL repeat_%0d got %h/%b want %h/%b",
                 i, a_t, a_chg, ea, exp_chg);
      end
      if (a_chg === 1'b1) pulses++;
    end
    inc = 1'b0;
    checks++;
    if (pulses != 4) begin
      errs++;
      $display("FAIL repeat_pulses got %0d want 4", pulses);
    end
    qa.push_back(24'h001400);
    qb.push_back(24'h011400);
    @(negedge clk);
    cmp_q("repeat_end");
  endtask

  task automatic test_conflict;
    inc = 1'b1;
    dec = 1'b1;
    qa.push_back(24'h001400);
    qb.push_back(24'h011400);
    repeat (2) @(negedge clk);
    cmp_q("conflict");
    checks++;
    if (a_chg !== 1'b0) begin
      errs++;
      $display("FAIL conflict_chg got %b want 0", a_chg);
    end
    dec = 1'b0;
    @(negedge clk);
    qa.push_back(24'h001400);
    qb.push_back(24'h011400);
    cmp_q("conflict_held");
    inc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sel_step;
    enter(24'h102030);
    qa.push_back(24'h112030);
    qb.push_back(24'h112000);
    press(1, 0, 1);
    cmp_q("selstep_old");
    @(negedge clk);
    qa.push_back(24'h112130);
    qb.push_back(24'h112100);
    press(1, 0, 0);
    cmp_q("selstep_new");
    @(negedge clk);
  endtask

  task automatic test_cursor;
    enter(24'h000000);
    press(0, 0, 1);
    checks++;
    if ({b_lh, b_lm, b_ls, a_lm} !== 4'b0101) begin
      errs++;
      $display("FAIL cursor1 got %b want 0101",
               {b_lh, b_lm, b_ls, a_lm});
    end
    @(negedge clk);
    press(0, 0, 1);
    checks++;
    if ({b_lh, b_lm, b_ls, a_ls} !== 4'b1001) begin
      errs++;
      $display("FAIL cursor2 got %b want 1001",
               {b_lh, b_lm, b_ls, a_ls});
    end
    @(negedge clk);
    press(0, 0, 1);
    checks++;
    if ({b_lh, b_lm, b_ls, a_lh} !== 4'b0101) begin
      errs++;
      $display("FAIL cursor3 got %b want 0101",
               {b_lh, b_lm, b_ls, a_lh});
    end
    @(negedge clk);
  endtask

  task automatic test_run_mode;
    mode = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_lh, a_lm, a_ls, a_blink} !== 4'b0) begin
      errs++;
      $display("FAIL run_leds got %b want 0000",
               {a_lh, a_lm, a_ls, a_blink});
    end
    qa.push_back(24'h000000);
    qb.push_back(24'h010000);
    press(1, 0, 0);
    cmp_q("run_inc");
    checks++;
    if (a_chg !== 1'b0) begin
      errs++;
      $display("FAIL run_chg got %b want 0", a_chg);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_hold;
    mode = 1'b0;
    inc  = 1'b1;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    qa.push_back(24'h000000);
    qb.push_back(24'h120000);
    repeat (3) @(negedge clk);
    cmp_q("rst_hold");
    checks++;
    if (a_chg !== 1'b0) begin
      errs++;
      $display("FAIL rst_hold_chg got %b want 0", a_chg);
    end
    inc = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    clk  = 1'b0;
    rst  = 1'b1;
    mode = 1'b1;
    sel  = 1'b0;
    inc  = 1'b0;
    dec  = 1'b0;
    t_i  = 24'h0;
    test_reset;
    test_load;
    test_wrap24;
    test_wrap12;
    test_blink;
    test_repeat;
    test_conflict;
    test_sel_step;
    test_cursor;
    test_run_mode;
    test_reset_hold;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Parametrised BCD time-setting controller for the clock/alarm datapath. It is the next generation of the alarm hour/minute setter and adds:
- an optional seconds field
- a 12/24-hour range
- increment and decrement
- hold-to-auto-repeat
- a field cursor
- a blink strobe for the display

It sits between the push-button inputs and the alarm/time compare registers. It loads the current time on entry to set mode and presents the edited BCD digits.

## Interface
- SEC_EN, 1 — 1: seconds field present and selectable; 0: sec outputs forced 0, cursor skips SEC
- HR24, 1 — 1: hours range 00–23; 0: hours range 01–12
- HOLD_CYCLES, 50_000_000 — continuous-hold cycles before auto-repeat starts (≥2)
- REPEAT_CYCLES, 10_000_000 — cycles between auto-repeat steps (≥1)
- BLINK_CYCLES, 25_000_000 — half-period of blink_o (≥1)
- clk  in  1  system clock; one clock for the whole block
- rst  in  1  reset, synchronous, active-high
- mode  in  1  1 = run (hold), 0 = set
- sel  in  1  level button; rising edge advances cursor
- inc  in  1  level button; step selected field +1
- dec  in  1  level button; step selected field −1
- hr_high_i, hr_low_i, min_high_i, min_low_i, sec_high_i, sec_low_i  in  4 each  live time, BCD
- hr_high_o, hr_low_o, min_high_o, min_low_o, sec_high_o, sec_low_o  out  4 each  edited time, BCD, registered
- LED_hr, LED_min, LED_sec  out  1 each  cursor indicators, high only while mode=0
- blink_o  out  1  display blink strobe
- changed_o  out  1  one-cycle pulse per applied step

All inputs are synchronous to clk.

## Operation
- **Input sampling:** mode, sel, inc and dec are registered each cycle into mode_t, sel_t, inc_t and dec_t. A rising edge is current=1 with the registered copy=0.
- **Per-cycle priority:**
  1. rst
  2. Load (mode_t=1, mode=0)
  3. Exit (mode_t=0, mode=1): no action
  4. mode=1: hold all values
  5. Set-mode actions
- **Load:**
  - Copy each field from the *_i inputs.
  - A field that is out of range loads its minimum instead. Out of range means a digit >9, hr >23 (HR24=1), hr not in 1–12 (HR24=0), or min/sec >59.
  - Minimum values: hr 00 (HR24=1) or 01 (HR24=0); min and sec 00.
  - Cursor resets to HR. Repeat counter clears. changed_o stays 0.
- **Cursor:** a rising edge of sel cycles HR→MIN→SEC→HR. With SEC_EN=0 the cycle is HR→MIN→HR.
- **Steps:**
  - inc adds 1 to the selected field as a two-digit BCD value; dec subtracts 1.
  - The low digit carries or borrows into the high digit.
  - Wrap: hr 23→00 / 00→23 (HR24=1); hr 12→01 / 01→12 (HR24=0); min and sec 59→00 / 00→59.
  - Only the selected field changes. There is no carry between fields.
- **Auto-repeat:**
  - A rising edge of inc (or dec) steps at that edge and starts hcnt=0.
  - While the button stays high and the other stays low, hcnt increments every cycle.
  - The next step is taken when hcnt reaches HOLD_CYCLES. Further steps follow every REPEAT_CYCLES.
  - Releasing the button clears the repeat state.
- **Simultaneous inc and dec high:** no step is taken and the repeat state clears. A step resumes only on a fresh rising edge.
- **Simultaneous sel edge with a step:** the cursor moves and the step applies to the field selected *before* the move.
- **Indicators:**
  - LED_hr, LED_min and LED_sec are the one-hot cursor ANDed with !mode (combinational from registers).
  - LED_sec is always 0 when SEC_EN=0.
- **blink_o:**
  - While mode=0, toggles every BLINK_CYCLES cycles.
  - Forced to 1 for one BLINK_CYCLES interval after each step, so the edited digits stay visible.
  - Forced to 0 while mode=1.
- **changed_o:** 1 for exactly the cycle following each applied step.

## Timing
- **Reset values:**
  - hr_*_o = 0,0 (HR24=1) or 1,2 (HR24=0).
  - min, sec, LED_hr, LED_min, LED_sec, blink_o and changed_o = 0.
  - Cursor = HR. All registered input copies = 0.
- **Step latency:** a step updates the outputs at the same clk edge where the rising edge is detected, so the new value is visible one cycle after inc first samples high.
- **Load latency:** the outputs show the loaded time one cycle after mode first samples 0.
- **Repeat timing:** with the first step at edge k, repeat steps occur at k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, and so on.
- **Reset mid-hold:** reset returns all state to reset values. A button still held after reset does not produce a step until it is released and pressed again, because its registered copy goes high the cycle after reset.
- **Mode entry with a button already held:** no step is taken on the load cycle. The held button needs a fresh rising edge.

## Test plan
- **Reset and load:** rst with HR24=1, then mode 1→0 with time_i=14:37:52 → outputs 00:00:00 after reset; 14:37:52 one cycle after load; LED_hr=1; changed_o=0.
- **Invalid load:** load hr_i=2,5, min_i=6,1, sec_i=0,9 (HR24=1) → loaded value 00:00:09.
- **Wrap in 24-hour mode:** at 23:59:00, inc on HR → 00:59:00. sel, then inc → 00:00:00 (no hour carry). dec → 00:59:00.
- **Wrap in 12-hour mode:** HR24=0, hr 12, inc → 01. dec twice → 11.
- **Auto-repeat:** HOLD_CYCLES=4, REPEAT_CYCLES=2, min=10, hold inc 9 cycles → steps at k, k+4, k+6, k+8; min=14; four changed_o pulses.
- **Conflicts and cursor:**
  - inc and dec both high → no change.
  - SEC_EN=0: three sel edges → cursor HR→MIN→HR→MIN; LED_sec stays 0.
  - mode=1 → LEDs and blink_o are 0; inc is ignored.
